// File: rtl/tmip_out_collect_if.sv
// Handshake bundle between the TMIP serial result stream and the word collector.
interface tmip_out_collect_if #(parameter int WORD_W = 20);
  logic              start;
  logic [1:0]        image_size;
  logic              out_valid;
  logic              out_value;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [7:0]        word_idx;
  logic [WORD_W-1:0] max_value;
  logic [7:0]        max_idx;
  logic              done;
  logic              err;

  modport master (
    output start, image_size, out_valid, out_value,
    input  word_valid, word_data, word_idx, max_value, max_idx, done, err
  );
  modport slave (
    input  start, image_size, out_valid, out_value,
    output word_valid, word_data, word_idx, max_value, max_idx, done, err
  );
endinterface

// File: rtl/tmip_out_collect.sv
// Deserialises MSB-first TMIP result bits into WORD_W-bit words for one frame,
// tracking the running maximum and flagging protocol errors.
module tmip_out_collect #(
  parameter int WORD_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  tmip_out_collect_if.slave bus
);
  localparam int CW = $clog2(WORD_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d, shifted;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [8:0]        word_cnt_q, word_cnt_d;
  logic [8:0]        frame_q, frame_d;
  logic              word_valid_q, word_valid_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic [WORD_W-1:0] max_value_q, max_value_d;
  logic [7:0]        max_idx_q, max_idx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    frame_d      = frame_q;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    word_idx_d   = word_idx_q;
    max_value_d  = max_value_q;
    max_idx_d    = max_idx_q;
    done_d       = done_q;
    err_d        = err_q;
    shifted      = {sh_q[WORD_W-2:0], bus.out_value};

    // start wins over everything, including a bit arriving in the same cycle
    if (bus.start) begin
      state_d     = ST_ARMED;
      bit_cnt_d   = '0;
      word_cnt_d  = '0;
      max_value_d = '0;
      max_idx_d   = '0;
      done_d      = 1'b0;
      err_d       = (bus.image_size == 2'd3);
      case (bus.image_size)
        2'd1:    frame_d = 9'd64;
        2'd2:    frame_d = 9'd256;
        default: frame_d = 9'd16;
      endcase
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (bus.out_valid) begin
            sh_d      = {{(WORD_W-1){1'b0}}, bus.out_value};
            bit_cnt_d = CW'(1);
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.out_valid) begin
            sh_d      = shifted;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(WORD_W - 1)) begin
              word_valid_d = 1'b1;
              word_data_d  = shifted;
              word_idx_d   = word_cnt_q[7:0];
              word_cnt_d   = word_cnt_q + 9'd1;
              bit_cnt_d    = '0;
              // strict compare keeps the earliest index on ties
              if (shifted > max_value_q) begin
                max_value_d = shifted;
                max_idx_d   = word_cnt_q[7:0];
              end
              if (word_cnt_q + 9'd1 == frame_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_ARMED;
              end
            end
          end else begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_ARMED;
          end
        end
        ST_DONE: begin
          if (bus.out_valid) err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      frame_q      <= 9'd16;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_idx_q   <= '0;
      max_value_q  <= '0;
      max_idx_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      frame_q      <= frame_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_idx_q   <= word_idx_d;
      max_value_q  <= max_value_d;
      max_idx_q    <= max_idx_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign bus.word_idx   = word_idx_q;
  assign bus.max_value  = max_value_q;
  assign bus.max_idx    = max_idx_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_tmip_out_collect.sv
// Directed bench for tmip_out_collect: serial words in, scoreboard of expected strobes out.
module tb_tmip_out_collect;
  localparam int W = 20;

  logic clk;
  logic rst_n;
  tmip_out_collect_if #(.WORD_W(W)) bus();

  tmip_out_collect #(.WORD_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [7:0]   idx;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           strobes = 0;
  int           widx;
  logic [W-1:0] exp_max;
  int           exp_midx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: every strobe must match the oldest expected word
  always @(posedge clk) begin
    #1;
    if (bus.word_valid === 1'b1) begin
      strobes++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("word_data", 32'(bus.word_data), 32'(mon_e.data));
        chk("word_idx", 32'(bus.word_idx), 32'(mon_e.idx));
        chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic do_start(input logic [1:0] s);
    @(negedge clk);
    bus.start = 1'b1; bus.image_size = s; bus.out_valid = 1'b0;
    widx = 0; exp_max = '0; exp_midx = 0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.out_valid = 1'b0; bus.out_value = 1'b0;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    exp_t e;
    for (int b = W - 1; b >= 0; b--) begin
      @(negedge clk);
      bus.out_valid = 1'b1; bus.out_value = w[b];
    end
    e.data = w; e.idx = 8'(widx); e.cyc = cyc + 1;
    sb.push_back(e);
    if (w > exp_max) begin exp_max = w; exp_midx = widx; end
    widx++;
  endtask

  task automatic send_partial(input logic [W-1:0] w, input int n);
    for (int b = W - 1; b >= W - n; b--) begin
      @(negedge clk);
      bus.out_valid = 1'b1; bus.out_value = w[b];
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_word_valid"}, 32'(bus.word_valid), 32'd0);
    chk({pfx, "_word_data"}, 32'(bus.word_data), 32'd0);
    chk({pfx, "_word_idx"}, 32'(bus.word_idx), 32'd0);
    chk({pfx, "_max_value"}, 32'(bus.max_value), 32'd0);
    chk({pfx, "_max_idx"}, 32'(bus.max_idx), 32'd0);
    chk({pfx, "_done"}, 32'(bus.done), 32'd0);
    chk({pfx, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    int s0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.image_size = 2'd0; bus.out_valid = 1'b0; bus.out_value = 1'b0;
    widx = 0; exp_max = '0; exp_midx = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // bits in IDLE are ignored silently
    send_partial(20'hFFFFF, 5);
    gap(3);
    chk("idle_err", 32'(bus.err), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);

    // size 0, words 0..15 back to back
    do_start(2'd0);
    for (int i = 0; i < 15; i++) send_word(W'(i));
    gap(2);
    chk("s1_done_early", 32'(bus.done), 32'd0);
    send_word(W'(15));
    gap(2);
    chk("s1_done", 32'(bus.done), 32'd1);
    chk("s1_err", 32'(bus.err), 32'd0);
    chk("s1_max", 32'(bus.max_value), 32'd15);
    chk("s1_max_idx", 32'(bus.max_idx), 32'd15);
    chk("s1_sb_empty", 32'(sb.size()), 32'd0);

    // size 1, random gaps, tie on 20'hFFFFF keeps idx 10
    do_start(2'd1);
    s0 = strobes;
    for (int i = 0; i < 64; i++) begin
      if (i == 10 || i == 40) send_word(20'hFFFFF);
      else send_word(W'($urandom_range(0, 20'hFFFFE)));
      gap($urandom_range(0, 3));
    end
    gap(2);
    chk("s2_strobes", 32'(strobes - s0), 32'd64);
    chk("s2_max", 32'(bus.max_value), 32'hFFFFF);
    chk("s2_max_idx", 32'(bus.max_idx), 32'd10);
    chk("s2_done", 32'(bus.done), 32'd1);
    chk("s2_err", 32'(bus.err), 32'd0);

    // word 3 truncated after 7 bits
    do_start(2'd0);
    for (int i = 0; i < 3; i++) send_word(W'(100 + i));
    send_partial(20'hABCDE, 7);
    gap(2);
    chk("s3_err", 32'(bus.err), 32'd1);
    chk("s3_idx_held", 32'(bus.word_idx), 32'd2);
    chk("s3_sb_empty", 32'(sb.size()), 32'd0);
    for (int i = 3; i < 16; i++) send_word(W'(200 + i));
    gap(2);
    chk("s3_done", 32'(bus.done), 32'd1);
    chk("s3_max", 32'(bus.max_value), 32'(exp_max));
    chk("s3_max_idx", 32'(bus.max_idx), 32'(exp_midx));

    // reset mid-word at size 2
    do_start(2'd2);
    send_word(20'h12345);
    send_word(20'h54321);
    send_partial(20'hFFFFF, 10);
    chk("s4_pre_max", 32'(bus.max_value), 32'h54321);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("s4_rst");
    @(negedge clk);
    rst_n = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.out_valid = 1'b1; bus.out_value = i[0];
    end
    gap(2);
    chk("s4_ignored_strobes", 32'(strobes - s0), 32'd0);
    chk("s4_err", 32'(bus.err), 32'd0);
    chk("s4_done", 32'(bus.done), 32'd0);

    // extra bits in DONE, then restart clears
    do_start(2'd0);
    for (int i = 0; i < 16; i++) send_word(W'(i * 3 + 1));
    gap(2);
    chk("s5_done", 32'(bus.done), 32'd1);
    chk("s5_err_pre", 32'(bus.err), 32'd0);
    s0 = strobes;
    send_partial(20'hFFFFF, 3);
    gap(2);
    chk("s5_err", 32'(bus.err), 32'd1);
    chk("s5_no_strobe", 32'(strobes - s0), 32'd0);
    chk("s5_done_held", 32'(bus.done), 32'd1);
    do_start(2'd0);
    chk("s5_err_clr", 32'(bus.err), 32'd0);
    chk("s5_done_clr", 32'(bus.done), 32'd0);
    chk("s5_max_clr", 32'(bus.max_value), 32'd0);

    // start mid-frame (reserved size code -> 16 words + err)
    for (int i = 0; i < 5; i++) send_word(W'(500 + i));
    send_partial(20'h0F0F0, 8);
    do_start(2'd3);
    chk("s6_err", 32'(bus.err), 32'd1);
    chk("s6_done", 32'(bus.done), 32'd0);
    chk("s6_max_clr", 32'(bus.max_value), 32'd0);
    chk("s6_max_idx_clr", 32'(bus.max_idx), 32'd0);
    s0 = strobes;
    for (int i = 0; i < 16; i++) send_word(W'(i * 7));
    gap(2);
    chk("s6_strobes", 32'(strobes - s0), 32'd16);
    chk("s6_done_end", 32'(bus.done), 32'd1);
    chk("s6_max", 32'(bus.max_value), 32'd105);
    chk("s6_max_idx", 32'(bus.max_idx), 32'd15);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tmip_out_collect.md
TMIP_OUT_COLLECT -- requirements
Module: tmip_out_collect

Interface
REQ-001 SHALL have parameter WORD_W, default 20, meaning bits per serial result word.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse that arms collection of one result frame.
REQ-005 SHALL have port image_size  input  2  frame size code, sampled with start: 0 = 16 words, 1 = 64 words, 2 = 256 words, 3 = reserved.
REQ-006 SHALL have port out_valid  input  1  serial-valid from upstream TMIP.
REQ-007 SHALL have port out_value  input  1  serial result bit from TMIP, MSB first.
REQ-008 SHALL have port word_valid  output  1  one-cycle strobe: word_data and word_idx are valid.
REQ-009 SHALL have port word_data  output  WORD_W  assembled unsigned result word.
REQ-010 SHALL have port word_idx  output  8  raster index of word_data within the frame, 0-based.
REQ-011 SHALL have port max_value  output  WORD_W  running maximum of the words received in the current frame.
REQ-012 SHALL have port max_idx  output  8  index of max_value.
REQ-013 SHALL have port done  output  1  level, high once the full frame has been received.
REQ-014 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement states IDLE, ARMED, SHIFT and DONE.
REQ-016 SHALL, on start in any state, latch image_size, clear bit count, word count, max_value, max_idx, err and done, and enter ARMED; this aborts any partial frame without a word_valid.
REQ-017 SHALL treat image_size = 3 at start as 16 words and set err.
REQ-018 SHALL ignore out_valid in IDLE, with no err.
REQ-019 SHALL, in ARMED, on out_valid = 1, shift out_value into bit 0 of the shift register, set bit count = 1 and enter SHIFT.
REQ-020 SHALL, in ARMED, allow out_valid = 0 gaps of any length between words.
REQ-021 SHALL, in SHIFT, on out_valid = 1, shift left by one and insert out_value as the LSB.
REQ-022 SHALL, when the WORD_W-th bit is sampled, assert word_valid for exactly one cycle on the next cycle, with word_data = assembled word and word_idx = word count; end-to-end latency is 1 cycle.
REQ-023 SHALL, in the same cycle as that word_valid, increment the word count and update max_value/max_idx when word > max_value (strictly greater, unsigned).
REQ-024 SHALL keep the earliest index on ties; for an all-zero frame, max_value = 0 and max_idx = 0.
REQ-025 SHALL, after a completed word, enter DONE if the word count reaches the latched frame size, otherwise return to ARMED.
REQ-026 SHALL allow back-to-back words (out_valid continuously high) with no lost bit.
REQ-027 SHALL, in SHIFT, on out_valid = 0 with 1..WORD_W-1 bits collected, set err, discard the partial word without counting it, and return to ARMED.
REQ-028 SHALL hold done = 1 in DONE until the next start or reset.
REQ-029 SHALL, in DONE, on out_valid = 1, set err and ignore the bit.
REQ-030 SHALL hold word_data, word_idx, max_value and max_idx stable between updates.

Reset
REQ-031 SHALL, on rst_n = 0 at any time including mid-word, immediately enter IDLE and drive word_valid = 0, word_data = 0, word_idx = 0, max_value = 0, max_idx = 0, done = 0 and err = 0.
REQ-032 SHALL leave IDLE only on start after rst_n deasserts.

Verification
REQ-033 SHALL cover: start with size 0, then 16 back-to-back 20-bit words 0..15 -> 16 word_valid pulses, each 1 cycle after its LSB, with idx 0..15; max_value = 15, max_idx = 15; done = 1 after the 16th word; err = 0.
REQ-034 SHALL cover: size 1 with random gaps between words; the word at idx 10 = 20'hFFFFF and the word at idx 40 = 20'hFFFFF -> max_value = 20'hFFFFF, max_idx = 10, 64 strobes, done = 1.
REQ-035 SHALL cover: out_valid drops after 7 bits of word 3 -> err = 1, no strobe; the next full word is reported with idx 3.
REQ-036 SHALL cover: rst_n pulsed low mid-word at size 2 -> all outputs 0 immediately; out_valid is then ignored until start.
REQ-037 SHALL cover: extra out_valid bits in DONE -> err = 1, no strobe; a new start clears err and done.
REQ-038 SHALL cover: start asserted mid-frame -> counts are cleared, no strobe is emitted for the partial word, and the new frame is reported from idx 0.
